// File: rtl/op_stack.sv
// LIFO operand stack feeding the A/B operand registers of the stack CPU.
// Registered read port, combinational status from the stack pointer, and sticky error flags.
module op_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SW-1:0]    r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_rd;
  logic          w_replace;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_ovf_evt;
  logic          w_unf_evt;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SW'(DEPTH));
  // Low AW bits wrap DEPTH to 0, so top index at full is still DEPTH-1.
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign w_wr_idx  = r_sp[AW-1:0];

  assign w_rd      = (pop | tos) & ~w_empty;
  assign w_replace = push & pop & ~w_empty;
  assign w_do_push = push & ~w_replace & ~w_full;
  assign w_do_pop  = pop & ~push & ~w_empty;
  assign w_ovf_evt = push & ~w_replace & w_full;
  assign w_unf_evt = (pop | tos) & w_empty;

  // Storage is intentionally not reset; entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (w_replace) begin
      r_mem[w_top_idx] <= din;
    end else if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp   <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_sp <= r_sp + SW'(1);
      end else if (w_do_pop) begin
        r_sp <= r_sp - SW'(1);
      end
      if (w_rd) begin
        r_dout <= r_mem[w_top_idx];
      end
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end
      if (w_unf_evt) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign dout  = r_dout;
  assign count = r_sp;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_op_stack.sv
// Scoreboard bench for op_stack: a queue-based reference stack predicts status,
// and expected read data is queued at drive time and compared when dout updates.
module tb_op_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [4:0]       count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  op_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .tos   (tos),
    .din   (din),
    .dout  (dout),
    .count (count),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] ref_stk[$];
  logic [WIDTH-1:0] exp_rd[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_unf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_stk.delete();
    exp_rd.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, 32'(count), 32'(ref_stk.size()));
    check_eq({tag, "_empty"}, 32'(empty), 32'(ref_stk.size() == 0));
    check_eq({tag, "_full"},  32'(full),  32'(ref_stk.size() == DEPTH));
    check_eq({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    check_eq({tag, "_unf"},   32'(unf),   32'(m_unf));
    check_eq({tag, "_dout"},  32'(dout),  32'(m_dout));
  endtask

  // One clock of stimulus; the reference stack is advanced on pre-edge state.
  task automatic step(input logic p, input logic po, input logic t,
                      input logic [WIDTH-1:0] d, input string tag);
    bit rd_ok;
    @(negedge clk);
    push = p; pop = po; tos = t; din = d;
    rd_ok = 1'b0;
    if (po || t) begin
      if (ref_stk.size() > 0) begin
        exp_rd.push_back(ref_stk[$]);
        rd_ok = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end
    if (p && po && ref_stk.size() > 0) begin
      ref_stk[ref_stk.size()-1] = d;
    end else begin
      if (po && !p && ref_stk.size() > 0) void'(ref_stk.pop_back());
      if (p) begin
        if (ref_stk.size() < DEPTH) ref_stk.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rd_ok) begin
      if (exp_rd.size() > 0) m_dout = exp_rd.pop_front();
    end
    check_status(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq({tag, "_dout0"}, 32'(dout), 32'h0);
    check_eq({tag, "_cnt0"},  32'(count), 32'h0);
    check_eq({tag, "_empty1"}, 32'(empty), 32'h1);
    check_eq({tag, "_flags0"}, 32'({ovf, unf}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
    model_reset();

    apply_reset("rst");

    // LIFO order
    step(1, 0, 0, 8'h11, "lifo_p");
    step(1, 0, 0, 8'h22, "lifo_p");
    step(1, 0, 0, 8'h33, "lifo_p");
    check_eq("lifo_cnt3", 32'(count), 32'd3);
    step(0, 1, 0, 8'h00, "lifo_pop");
    check_eq("lifo_d33", 32'(dout), 32'h33);
    step(0, 1, 0, 8'h00, "lifo_pop");
    check_eq("lifo_d22", 32'(dout), 32'h22);
    step(0, 1, 0, 8'h00, "lifo_pop");
    check_eq("lifo_d11", 32'(dout), 32'h11);
    check_eq("lifo_empty", 32'(empty), 32'h1);

    // Full and overflow
    apply_reset("rst_full");
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i), "fill");
    step(1, 0, 0, 8'hAA, "ovf_push");
    check_eq("ovf_full", 32'(full), 32'h1);
    check_eq("ovf_cnt16", 32'(count), 32'd16);
    check_eq("ovf_flag", 32'(ovf), 32'h1);
    step(0, 0, 1, 8'h00, "ovf_tos");
    check_eq("ovf_tos0F", 32'(dout), 32'h0F);
    step(1, 0, 1, 8'hBB, "ovf_push_tos");
    check_eq("ovf_push_tos_d", 32'(dout), 32'h0F);

    // Underflow
    apply_reset("rst_unf");
    step(0, 1, 0, 8'h00, "unf_pop");
    step(0, 0, 1, 8'h00, "unf_tos");
    check_eq("unf_dout0", 32'(dout), 32'h0);
    check_eq("unf_flag", 32'(unf), 32'h1);
    step(1, 0, 0, 8'h5A, "unf_push");
    step(0, 0, 1, 8'h00, "unf_tos2");
    check_eq("unf_tos5A", 32'(dout), 32'h5A);
    check_eq("unf_sticky", 32'(unf), 32'h1);

    // Push and pop on empty: push proceeds, pop half underflows
    apply_reset("rst_pp_empty");
    step(1, 1, 0, 8'h3C, "pp_empty");
    check_eq("pp_empty_cnt", 32'(count), 32'd1);
    step(0, 0, 1, 8'h00, "pp_empty_tos");
    check_eq("pp_empty_d", 32'(dout), 32'h3C);

    // Replace top
    apply_reset("rst_rep");
    step(1, 0, 0, 8'h10, "rep_p");
    step(1, 0, 0, 8'h20, "rep_p");
    step(1, 1, 0, 8'h99, "rep");
    check_eq("rep_d20", 32'(dout), 32'h20);
    check_eq("rep_cnt2", 32'(count), 32'd2);
    step(0, 0, 1, 8'h00, "rep_tos");
    check_eq("rep_tos99", 32'(dout), 32'h99);
    for (int i = 0; i < DEPTH - 2; i++) step(1, 0, 0, 8'(8'hC0 + i), "rep_fill");
    step(1, 1, 1, 8'h42, "rep_full");
    check_eq("rep_full_d", 32'(dout), 32'hCD);
    check_eq("rep_full_noovf", 32'(ovf), 32'h0);
    step(0, 0, 1, 8'h00, "rep_full_tos");
    check_eq("rep_full_tos42", 32'(dout), 32'h42);

    // Asynchronous reset mid-operation with push held
    apply_reset("rst_mid");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i), "mid_p");
    step(0, 0, 1, 8'h00, "mid_tos");
    @(negedge clk);
    push = 1'b1; pop = 1'b0; tos = 1'b0; din = 8'h66;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("mid_cnt0", 32'(count), 32'h0);
    check_eq("mid_dout0", 32'(dout), 32'h0);
    @(posedge clk);
    #1;
    check_status("mid_hold");
    @(negedge clk);
    rst = 1'b0; push = 1'b0;
    step(1, 0, 0, 8'h77, "mid_p77");
    step(0, 0, 1, 8'h00, "mid_tos77");
    check_eq("mid_d77", 32'(dout), 32'h77);
    check_eq("mid_cnt1", 32'(count), 32'd1);

    // Random traffic against the reference stack
    apply_reset("rst_rand");
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 8'($urandom), "rand");
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/op_stack.md
# op_stack

Hardware operand stack for the multicycle stack CPU's data path. It sits directly upstream of the A/B operand registers. It stores words written back from memory or the ALU (push) and returns the top-of-stack value on `tos` or `pop`. It is driven by the controller's `push`, `pop` and `tos` strobes. Full/empty status and sticky error flags are exported for debug and for future trap logic.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of stack entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `push`, input, 1: write `din` onto the stack this cycle.
- `pop`, input, 1: remove the top entry and load it into `dout`.
- `tos`, input, 1: load the top entry into `dout` without removing it.
- `din`, input, WIDTH: data to push.
- `dout`, output, WIDTH: registered read data.
- `count`, output, clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `ovf`, output, 1: sticky overflow flag.
- `unf`, output, 1: sticky underflow flag.

## Operation
- State:
  - storage array `mem[DEPTH]`;
  - pointer `sp`, width clog2(DEPTH)+1, which equals `count`;
  - registered `dout`;
  - registers `ovf` and `unf`.
- The top entry is `mem[sp-1]`; it is valid only when `sp > 0`.
- Per-cycle actions, all evaluated on pre-edge state:
  - **push only:**
    - if not full: `mem[sp] <= din`, `sp <= sp+1`;
    - if full: no write, `sp` unchanged, `ovf <= 1`.
  - **pop only:**
    - if not empty: `dout <= mem[sp-1]`, `sp <= sp-1`;
    - if empty: `dout` and `sp` unchanged, `unf <= 1`.
  - **tos only:**
    - if not empty: `dout <= mem[sp-1]`, `sp` unchanged;
    - if empty: `dout` unchanged, `unf <= 1`.
  - **pop and tos together:** identical to pop only; tos is redundant.
  - **push and pop, not empty (replace top):**
    - `dout <= old mem[sp-1]`, `mem[sp-1] <= din`, `sp` unchanged;
    - allowed when full, with no `ovf`.
  - **push and pop, empty:**
    - push proceeds: `mem[0] <= din`, `sp <= 1`;
    - the pop half underflows: `unf <= 1`, `dout` unchanged.
  - **push and tos, no pop:**
    - `dout <= old top` if not empty, else `unf <= 1`;
    - the push is handled as in "push only", including `ovf` when full.
- `ovf` and `unf` are cleared only by `rst`.
- Overflow and underflow never corrupt stored data or move `sp` out of 0..DEPTH.
- `mem` is not reset. Contents above `sp` are don't-care and never reach `dout`.
- `count = sp`, `empty = (sp == 0)`, `full = (sp == DEPTH)`; all three are combinational from registered `sp`.

## Timing
- Reset values, effective immediately on `rst` assertion (asynchronous):
  - `sp = 0`, so `count = 0`, `empty = 1`, `full = 0`;
  - `dout = 0`, `ovf = 0`, `unf = 0`.
- Reset deassertion is assumed synchronous to `clk` upstream. The first operation is honoured at the first rising edge after deassertion.
- Reset asserted mid-sequence discards the stack: `sp = 0` and the flags clear. A strobe present in the reset cycle has no effect.
- Read latency is one cycle: `dout` is valid the cycle after `pop`/`tos` and holds until the next successful `pop`/`tos`.
- Push-to-read latency is one cycle: a `tos` in the cycle after a `push` returns the pushed value. No same-cycle forwarding of `din` to `dout`.
- Strobes are level-sampled every edge; holding `push` high for N cycles performs N pushes.
- Throughput is one operation per cycle; no stalls and no handshake.

## Test plan
- **Reset:** assert `rst` between edges.
  - Check immediately: `dout = 0`, `count = 0`, `empty = 1`, `ovf = unf = 0`.
- **Push/pop LIFO order:** push 0x11, 0x22, 0x33.
  - Expect `count = 3`.
  - Then pop x3: `dout` is 0x33, 0x22, 0x11 on consecutive cycles; `empty = 1` at the end.
- **Full/overflow (DEPTH=16):** push 0x00..0x0F, then push 0xAA.
  - Expect `full = 1`, `count = 16`, `ovf = 1`.
  - Subsequent `tos` returns 0x0F, not 0xAA.
- **Underflow:** from reset, `pop` then `tos`.
  - Expect `dout = 0`, `count = 0`, `unf = 1`.
  - Then push 0x5A followed by `tos`: `dout = 0x5A`, and `unf` remains 1.
- **Replace top:** stack holds [0x10, 0x20]; assert push+pop with `din = 0x99`.
  - Expect `dout = 0x20`, `count = 2`; next `tos` gives `dout = 0x99`.
  - Repeat with the stack full: no `ovf`.
- **Async reset mid-operation:** with `count = 5`, assert `rst` while `push = 1`.
  - Expect `count = 0` and `dout = 0` immediately.
  - After release, push 0x77 then `tos`: `dout = 0x77`, `count = 1`.
